deserializer: RTL

//   Downstream stage of the serializer: collects the MSB-first serial stream
//   (ser_data_o / ser_data_val_o) back into parallel words.

---
 rtl/deserializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel collector for the MSB-first serializer stream.
// Optional idle flush of partial words when DESER_FLUSH_EN is defined.
module deserializer #(
  parameter int DATA_W       = 16,
  parameter int IDLE_TIMEOUT = 8,
  localparam int MOD_W       = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  localparam logic [MOD_W:0] LAST = (MOD_W+1)'(DATA_W-1);
  localparam logic [MOD_W:0] FULL = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] ONE  = (MOD_W+1)'(1);

  if (DATA_W < 2) begin : g_chk_w
    $error("DATA_W must be >= 2");
  end
  if (IDLE_TIMEOUT < 1) begin : g_chk_t
    $error("IDLE_TIMEOUT must be >= 1");
  end

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] word_nx;
  logic [MOD_W:0]    bit_cnt;
  logic [MOD_W:0]    cnt_nx;
  logic              val_q;
  logic              val_nx;
  logic              busy_q;
  logic              flush;
  logic              full;

`ifdef DESER_FLUSH_EN
  localparam int IW = $clog2(IDLE_TIMEOUT+1);
  localparam logic [IW-1:0] TMO = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IONE = IW'(1);

  logic [IW-1:0]    idle_cnt;
  logic [IW-1:0]    idle_nx;
  logic [MOD_W-1:0] mod_q;

  assign flush = (idle_cnt == TMO) && (bit_cnt != '0);

  always_comb begin
    idle_nx = idle_cnt;
    if (data_val_i || bit_cnt == '0)
      idle_nx = '0;
    else if (idle_cnt != TMO)
      idle_nx = idle_cnt + IONE;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      idle_cnt <= '0;
      mod_q    <= '0;
    end else begin
      idle_cnt <= idle_nx;
      if (val_nx)
        mod_q <= flush ? bit_cnt[MOD_W-1:0] : '0;
    end
  end

  assign deser_mod_o = mod_q;
`else
  assign flush       = 1'b0;
  assign deser_mod_o = '0;
`endif

  // A flush and a new bit in the same cycle: partial goes out, bit starts a new word
  always_comb begin
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    word_nx  = data_q;
    val_nx   = 1'b0;
    full     = data_val_i && !flush && (bit_cnt == LAST);
    if (flush) begin
      word_nx = shreg << (FULL - bit_cnt);
      val_nx  = 1'b1;
      cnt_nx  = '0;
    end
    if (data_val_i) begin
      shreg_nx = {shreg[DATA_W-2:0], data_i};
      if (full) begin
        word_nx = shreg_nx;
        val_nx  = 1'b1;
        cnt_nx  = '0;
      end else begin
        cnt_nx = cnt_nx + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shreg   <= shreg_nx;
      bit_cnt <= cnt_nx;
      data_q  <= word_nx;
      val_q   <= val_nx;
      busy_q  <= (cnt_nx != '0);
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = busy_q;

endmodule
